// File: rtl/st2mm_csr_pkg.sv
// Shared definitions for the ST2MM CSR MMIO slave.
//   RESP_OKAY / RESP_SLVERR : AXI response codes driven on bresp/rresp.
//   CSR_ADDR_LSB            : byte-to-QWORD address shift for the CSR port.
//   t_mmio_slv_state        : transaction FSM states, also exported on dbg_state.
package st2mm_csr_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CSR_ADDR_LSB = 3;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_DATA  = 4'd1,
        S_WR_CSR   = 4'd2,
        S_WR_DRAIN = 4'd3,
        S_WR_RESP  = 4'd4,
        S_RD_CSR   = 4'd5,
        S_RD_WAIT  = 4'd6,
        S_RD_RESP  = 4'd7,
        S_RD_ERR   = 4'd8
    } t_mmio_slv_state;

endpackage

// File: rtl/st2mm_csr_mmio_slave.sv
// AXI4 MMIO slave that terminates the ST2MM CSR converter's AXI4 port and
// drives a single-cycle CSR register port.
//   AXI AW/W/B : single-beat writes become one csr_wr_en pulse; bursts are
//                drained and answered with SLVERR.
//   AXI AR/R   : single-beat reads become one csr_rd_en pulse, then wait for
//                csr_rd_ack (bounded by RD_TIMEOUT); bursts return arlen+1
//                SLVERR beats without touching the register file.
//   CSR port   : csr_wr_en/csr_rd_en pulses, QWORD csr_addr, csr_wdata,
//                csr_wstrb; csr_rd_ack/csr_rdata return read data.
//   dbg_state  : current FSM state.
// Handshake rule on every AXI channel: a beat transfers on a rising clk edge
// where valid && ready; a source holds valid and its payload stable until
// that edge. Only one transaction is in flight at a time.
module st2mm_csr_mmio_slave
    import st2mm_csr_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 64,
    parameter int ID_W       = 10,
    parameter int RD_TIMEOUT = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    // write address
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [ADDR_W-1:0]              awaddr,
    input  logic [ID_W-1:0]                awid,
    input  logic [7:0]                     awlen,
    input  logic [2:0]                     awsize,
    input  logic [1:0]                     awburst,
    input  logic [2:0]                     awprot,
    // write data
    input  logic                           wvalid,
    output logic                           wready,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [DATA_W/8-1:0]            wstrb,
    input  logic                           wlast,
    // write response
    output logic                           bvalid,
    input  logic                           bready,
    output logic [ID_W-1:0]                bid,
    output logic [1:0]                     bresp,
    // read address
    input  logic                           arvalid,
    output logic                           arready,
    input  logic [ADDR_W-1:0]              araddr,
    input  logic [ID_W-1:0]                arid,
    input  logic [7:0]                     arlen,
    input  logic [2:0]                     arsize,
    input  logic [1:0]                     arburst,
    input  logic [2:0]                     arprot,
    // read data
    output logic                           rvalid,
    input  logic                           rready,
    output logic [DATA_W-1:0]              rdata,
    output logic [ID_W-1:0]                rid,
    output logic [1:0]                     rresp,
    output logic                           rlast,
    // CSR register port
    output logic                           csr_wr_en,
    output logic                           csr_rd_en,
    output logic [ADDR_W-CSR_ADDR_LSB-1:0] csr_addr,
    output logic [DATA_W-1:0]              csr_wdata,
    output logic [DATA_W/8-1:0]            csr_wstrb,
    input  logic                           csr_rd_ack,
    input  logic [DATA_W-1:0]              csr_rdata,
    // debug
    output t_mmio_slv_state                dbg_state
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int QADDR_W = ADDR_W - CSR_ADDR_LSB;
    localparam int CNT_W   = $clog2(RD_TIMEOUT + 1);

    t_mmio_slv_state     state_q, state_d;
    logic                last_wr_q, last_wr_d;
    logic [QADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          beat_q, beat_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
    logic [ID_W-1:0]     bid_q, bid_d;
    logic [ID_W-1:0]     rid_q, rid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;

    // Attribute fields and the byte offset inside a QWORD carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{awsize, awburst, awprot, arsize, arburst, arprot,
                         awaddr[CSR_ADDR_LSB-1:0], araddr[CSR_ADDR_LSB-1:0]};

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        tmo_d     = tmo_q;
        bid_d     = bid_q;
        rid_d     = rid_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;

        awready   = 1'b0;
        arready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        csr_wr_en = 1'b0;
        csr_rd_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Readies stay low while reset is held so nothing is accepted
                // that reset is about to discard.
                if (!rst) begin
                    // On contention the grant goes to the side that did not
                    // win last time, giving strict W/R alternation.
                    if (awvalid && (!arvalid || !last_wr_q)) begin
                        awready   = 1'b1;
                        bid_d     = awid;
                        addr_d    = awaddr[ADDR_W-1:CSR_ADDR_LSB];
                        len_d     = awlen;
                        last_wr_d = 1'b1;
                        state_d   = (awlen == 8'd0) ? S_WR_DATA : S_WR_DRAIN;
                    end else if (arvalid) begin
                        arready   = 1'b1;
                        rid_d     = arid;
                        addr_d    = araddr[ADDR_W-1:CSR_ADDR_LSB];
                        len_d     = arlen;
                        last_wr_d = 1'b0;
                        if (arlen == 8'd0) begin
                            state_d = S_RD_CSR;
                        end else begin
                            beat_d  = 8'd0;
                            rdata_d = '0;
                            rresp_d = RESP_SLVERR;
                            state_d = S_RD_ERR;
                        end
                    end
                end
            end

            S_WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    state_d = S_WR_CSR;
                end
            end

            S_WR_CSR: begin
                csr_wr_en = 1'b1;
                bresp_d   = RESP_OKAY;
                state_d   = S_WR_RESP;
            end

            S_WR_DRAIN: begin
                // Burst beats are swallowed; the register file never sees them.
                wready = 1'b1;
                if (wvalid && wlast) begin
                    bresp_d = RESP_SLVERR;
                    state_d = S_WR_RESP;
                end
            end

            S_WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_d = S_IDLE;
                end
            end

            S_RD_CSR: begin
                csr_rd_en = 1'b1;
                tmo_d     = '0;
                if (csr_rd_ack) begin
                    rdata_d = csr_rdata;
                    rresp_d = RESP_OKAY;
                    state_d = S_RD_RESP;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end

            S_RD_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (csr_rd_ack) begin
                    rdata_d = csr_rdata;
                    rresp_d = RESP_OKAY;
                    state_d = S_RD_RESP;
                end else if (tmo_d == CNT_W'(RD_TIMEOUT)) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    state_d = S_RD_RESP;
                end
            end

            S_RD_RESP: begin
                rvalid = 1'b1;
                rlast  = 1'b1;
                if (rready) begin
                    state_d = S_IDLE;
                end
            end

            S_RD_ERR: begin
                // beat_q counts beats already sent; comparing against len_q
                // (not len_q+1) keeps arlen=255 inside 8 bits.
                rvalid = 1'b1;
                rlast  = (beat_q == len_q);
                if (rready) begin
                    if (beat_q == len_q) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_wr_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            tmo_q     <= '0;
            bid_q     <= '0;
            rid_q     <= '0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            tmo_q     <= tmo_d;
            bid_q     <= bid_d;
            rid_q     <= rid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign bid       = bid_q;
    assign bresp     = bresp_q;
    assign rid       = rid_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;
    assign csr_addr  = addr_q;
    assign csr_wdata = wdata_q;
    assign csr_wstrb = wstrb_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_st2mm_csr_mmio_slave.sv
// Bench for st2mm_csr_mmio_slave: directed scenarios followed by randomized
// single/burst reads and writes, checked against a QWORD register model.
module tb_st2mm_csr_mmio_slave;
    import st2mm_csr_pkg::*;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 64;
    localparam int ID_W       = 10;
    localparam int RD_TIMEOUT = 256;
    localparam int BUDGET     = 600;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [ID_W-1:0]   awid, arid, bid, rid;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, awprot, arsize, arprot;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic [63:0]       wdata, rdata, csr_wdata, csr_rdata;
    logic [7:0]        wstrb, csr_wstrb;
    logic              arvalid, arready, rvalid, rready, rlast;
    logic              csr_wr_en, csr_rd_en, csr_rd_ack;
    logic [12:0]       csr_addr;
    t_mmio_slv_state   dbg_state;

    logic              resp_ack, inj_ack;
    logic [63:0]       resp_data, inj_data;
    assign csr_rd_ack = resp_ack | inj_ack;
    assign csr_rdata  = inj_ack ? inj_data : resp_data;

    st2mm_csr_mmio_slave #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
        .rresp(rresp), .rlast(rlast),
        .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_wstrb(csr_wstrb),
        .csr_rd_ack(csr_rd_ack), .csr_rdata(csr_rdata),
        .dbg_state(dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;

    logic [63:0] ref_mem [int];   // expected register contents, from transactions
    logic [63:0] rf      [int];   // register file emulated behind the CSR port
    logic [7:0]  grant_q [$];     // 'W' / 'R' in AXI grant order

    int          ack_delay = 0;   // cycles from csr_rd_en to ack; <0 = never
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [12:0] pend_addr = '0;
    int          wr_pulses = 0, rd_pulses = 0, pulse_overlap = 0, ready_overlap = 0;
    int          last_wr_cyc = 0, last_rd_cyc = 0;
    logic [12:0] last_wr_addr = '0, last_rd_addr = '0;
    logic [63:0] last_wr_data = '0;
    logic [7:0]  last_wr_strb = '0;
    int          aw_cyc = 0, ar_cyc = 0, b_cyc = 0, r_cyc = 0;

    function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] d, logic [7:0] s);
        logic [63:0] v = old;
        for (int b = 0; b < 8; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    function automatic logic [63:0] ref_get(int k);
        return ref_mem.exists(k) ? ref_mem[k] : 64'd0;
    endfunction

    function automatic logic [63:0] rf_get(int k);
        return rf.exists(k) ? rf[k] : 64'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- CSR register-file responder ----------------
    always @(negedge clk) begin
        resp_ack = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (csr_wr_en) begin
                wr_pulses++;
                last_wr_cyc  = cyc;
                last_wr_addr = csr_addr;
                last_wr_data = csr_wdata;
                last_wr_strb = csr_wstrb;
                rf[int'(csr_addr)] = merge(rf_get(int'(csr_addr)), csr_wdata, csr_wstrb);
            end
            if (csr_wr_en && csr_rd_en) pulse_overlap++;
            if (csr_rd_en) begin
                rd_pulses++;
                last_rd_cyc  = cyc;
                last_rd_addr = csr_addr;
                pend      = 1'b1;
                pend_cnt  = 0;
                pend_addr = csr_addr;
            end
            if (pend) begin
                if (ack_delay >= 0 && pend_cnt == ack_delay) begin
                    resp_ack  = 1'b1;
                    resp_data = rf_get(int'(pend_addr));
                    pend      = 1'b0;
                end else begin
                    pend_cnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_aw(input logic [15:0] a, input logic [9:0] id, input logic [7:0] len);
        bit hs = 1'b0;
        awaddr = a; awid = id; awlen = len; awsize = 3'd3; awburst = 2'd1; awprot = 3'd0;
        awvalid = 1'b1;
        for (int n = 0; n < BUDGET && !hs; n++) begin
            #1;
            hs = awready;
            if (awready && arready) ready_overlap++;
            if (hs) begin aw_cyc = cyc; grant_q.push_back(8'h57); end
            @(negedge clk);
        end
        awvalid = 1'b0;
        chk("aw_handshake", 64'(hs), 64'd1);
    endtask

    task automatic drive_ar(input logic [15:0] a, input logic [9:0] id, input logic [7:0] len);
        bit hs = 1'b0;
        araddr = a; arid = id; arlen = len; arsize = 3'd3; arburst = 2'd1; arprot = 3'd0;
        arvalid = 1'b1;
        for (int n = 0; n < BUDGET && !hs; n++) begin
            #1;
            hs = arready;
            if (awready && arready) ready_overlap++;
            if (hs) begin ar_cyc = cyc; grant_q.push_back(8'h52); end
            @(negedge clk);
        end
        arvalid = 1'b0;
        chk("ar_handshake", 64'(hs), 64'd1);
    endtask

    task automatic drive_w(input logic [63:0] d, input logic [7:0] s, input int beats);
        for (int i = 0; i < beats; i++) begin
            bit hs = 1'b0;
            wdata = d ^ 64'(i); wstrb = s; wlast = (i == beats - 1); wvalid = 1'b1;
            for (int n = 0; n < BUDGET && !hs; n++) begin
                #1; hs = wready;
                @(negedge clk);
            end
            chk("w_handshake", 64'(hs), 64'd1);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic collect_b(input logic [9:0] id, input logic [1:0] resp);
        bit hs = 1'b0;
        bready = 1'b1;
        for (int n = 0; n < BUDGET && !hs; n++) begin
            #1;
            hs = bvalid;
            if (hs) begin
                b_cyc = cyc;
                chk("bid", 64'(bid), 64'(id));
                chk("bresp", 64'(bresp), 64'(resp));
            end
            @(negedge clk);
        end
        bready = 1'b0;
        chk("b_handshake", 64'(hs), 64'd1);
    endtask

    task automatic collect_r(input logic [9:0] id, input int beats, input logic [63:0] d,
                             input logic [1:0] resp, input int hold);
        for (int beat = 0; beat < beats; beat++) begin
            bit hs = 1'b0;
            rready = (hold == 0);
            for (int n = 0; n < BUDGET && !hs; n++) begin
                #1;
                hs = rvalid;
                if (hs) begin
                    if (beat == 0) r_cyc = cyc;
                    chk("rid", 64'(rid), 64'(id));
                    chk("rresp", 64'(rresp), 64'(resp));
                    chk("rdata", rdata, d);
                    chk("rlast", 64'(rlast), 64'(beat == beats - 1));
                    for (int h = 0; h < hold; h++) begin
                        @(negedge clk); #1;
                        chk("hold_rvalid", 64'(rvalid), 64'd1);
                        chk("hold_rdata", rdata, d);
                        chk("hold_rid", 64'(rid), 64'(id));
                        chk("hold_rresp", 64'(rresp), 64'(resp));
                    end
                    rready = 1'b1;
                end
                @(negedge clk);
            end
            chk("r_handshake", 64'(hs), 64'd1);
        end
        rready = 1'b0;
    endtask

    // ---------------- transaction tasks with model ----------------
    task automatic do_write(input logic [15:0] a, input logic [9:0] id, input logic [7:0] len,
                            input logic [63:0] d, input logic [7:0] s);
        int k = int'(a[15:3]);
        int p0 = wr_pulses;
        logic [1:0] exp_resp = (len == 8'd0) ? RESP_OKAY : RESP_SLVERR;
        if (len == 8'd0) ref_mem[k] = merge(ref_get(k), d, s);
        drive_aw(a, id, len);
        drive_w(d, s, int'(len) + 1);
        collect_b(id, exp_resp);
        chk("wr_pulse_count", 64'(wr_pulses - p0), 64'(len == 8'd0));
        if (len == 8'd0) begin
            chk("csr_wr_addr", 64'(last_wr_addr), 64'(a >> 3));
            chk("csr_wr_data", last_wr_data, d);
            chk("csr_wr_strb", 64'(last_wr_strb), 64'(s));
            chk("wr_pulse_cycle", 64'(last_wr_cyc - aw_cyc), 64'd2);
            chk("b_latency", 64'(b_cyc - aw_cyc), 64'd3);
        end
    endtask

    task automatic do_read(input logic [15:0] a, input logic [9:0] id, input logic [7:0] len,
                           input int delay, input int hold);
        int p0 = rd_pulses;
        logic [63:0] exp_d;
        logic [1:0]  exp_resp;
        int          exp_lat;
        if (len != 8'd0) begin
            exp_d = '0; exp_resp = RESP_SLVERR; exp_lat = 1;
        end else if (delay < 0) begin
            exp_d = '0; exp_resp = RESP_SLVERR; exp_lat = 2 + RD_TIMEOUT;
        end else begin
            exp_d = ref_get(int'(a[15:3])); exp_resp = RESP_OKAY; exp_lat = 2 + delay;
        end
        ack_delay = delay;
        drive_ar(a, id, len);
        collect_r(id, int'(len) + 1, exp_d, exp_resp, hold);
        chk("rd_pulse_count", 64'(rd_pulses - p0), 64'(len == 8'd0));
        chk("r_latency", 64'(r_cyc - ar_cyc), 64'(exp_lat));
        if (len == 8'd0) chk("csr_rd_addr", 64'(last_rd_addr), 64'(a >> 3));
    endtask

    task automatic check_all_zero(input string p);
        chk({p, "_awready"}, 64'(awready), 64'd0);
        chk({p, "_arready"}, 64'(arready), 64'd0);
        chk({p, "_wready"}, 64'(wready), 64'd0);
        chk({p, "_bvalid"}, 64'(bvalid), 64'd0);
        chk({p, "_rvalid"}, 64'(rvalid), 64'd0);
        chk({p, "_rlast"}, 64'(rlast), 64'd0);
        chk({p, "_bid"}, 64'(bid), 64'd0);
        chk({p, "_rid"}, 64'(rid), 64'd0);
        chk({p, "_bresp"}, 64'(bresp), 64'd0);
        chk({p, "_rresp"}, 64'(rresp), 64'd0);
        chk({p, "_rdata"}, rdata, 64'd0);
        chk({p, "_csr_wr_en"}, 64'(csr_wr_en), 64'd0);
        chk({p, "_csr_rd_en"}, 64'(csr_rd_en), 64'd0);
        chk({p, "_csr_addr"}, 64'(csr_addr), 64'd0);
        chk({p, "_csr_wdata"}, csr_wdata, 64'd0);
        chk({p, "_csr_wstrb"}, 64'(csr_wstrb), 64'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int seen;
        rst = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0; awprot = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; arprot = 0;
        rready = 0; inj_ack = 0; inj_data = 0; resp_ack = 0; resp_data = 0;
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single-beat write and read with late ack
        do_write(16'h0010, 10'd5, 8'd0, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        do_write(16'h0018, 10'd1, 8'd0, 64'h0000_0000_0000_1234, 8'hFF);
        do_read(16'h0018, 10'd3, 8'd0, 4, 0);

        // timeout, stray ack, then a normal read
        do_read(16'h0018, 10'd4, 8'd0, -1, 0);
        inj_data = 64'hBAD0_BAD0_BAD0_BAD0; inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        seen = 0;
        repeat (3) begin #1 if (rvalid) seen++; @(negedge clk); end
        chk("stray_ack_ignored", 64'(seen), 64'd0);
        do_read(16'h0010, 10'd6, 8'd0, 2, 0);

        // contention after reset: strict alternation starting with write
        rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0; @(negedge clk);
        grant_q.delete();
        pulse_overlap = 0; ready_overlap = 0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    do_write(16'h0100 + 16'(i * 8), 10'(16 + i), 8'd0,
                             {$urandom, $urandom}, 8'($urandom_range(1, 255)));
            end
            begin
                for (int i = 0; i < 4; i++)
                    do_read((i % 2) ? 16'h0010 : 16'h0018, 10'(32 + i), 8'd0,
                            $urandom_range(0, 5), 0);
            end
        join
        chk("grant_count", 64'(grant_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < grant_q.size(); i++)
            chk("grant_order", 64'(grant_q[i]), (i % 2 == 0) ? 64'h57 : 64'h52);
        chk("csr_pulse_overlap", 64'(pulse_overlap), 64'd0);
        chk("ready_overlap", 64'(ready_overlap), 64'd0);

        // bursts
        do_write(16'h0020, 10'd7, 8'd3, 64'h1111_2222_3333_4444, 8'hFF);
        do_read(16'h0010, 10'd9, 8'd0, 0, 0);
        do_read(16'h0020, 10'd9, 8'd2, 0, 0);
        do_read(16'h0028, 10'h3FF, 8'd255, 0, 0);

        // backpressure on R
        do_read(16'h0018, 10'd11, 8'd0, 1, 10);

        // reset while waiting for the register file
        ack_delay = -1;
        drive_ar(16'h0030, 10'd12, 8'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (300) begin #1 if (rvalid) seen++; @(negedge clk); end
        chk("midrst_no_r_beat", 64'(seen), 64'd0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [15:0] a = {($urandom_range(0, 1) ? 3'b101 : 3'b000),
                              10'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
            logic [7:0] len = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 5)) : 8'd0;
            if ($urandom_range(0, 1) == 1)
                do_write(a, 10'($urandom), len, {$urandom, $urandom}, 8'($urandom));
            else
                do_read(a, 10'($urandom), len, $urandom_range(0, 6), $urandom_range(0, 3));
        end
        chk("final_csr_pulse_overlap", 64'(pulse_overlap), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
